gpc_f2c_port: RTL



---
 rtl/gpc_f2c_port.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gpc_f2c_port.sv
// GPC tile fabric-to-core slave port: region decode to NUM_MEM local memories,
// fixed-latency read tracking, buffered read responses under ring backpressure.
package gpc_f2c_pkg;
   typedef enum logic [1:0] {NOP = 2'd0, RD = 2'd1, WR = 2'd2, RD_RSP = 2'd3} t_opcode;
endpackage

module gpc_f2c_port
   import gpc_f2c_pkg::*;
#(
   parameter int NUM_MEM        = 2,
   parameter int REGION_LSB     = 22,
   parameter int MEM_RD_LAT     = 1,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                  QClk,
   input  logic                  RstQnnnH,
   input  logic                  F2C_ReqValidQ502H,
   input  t_opcode               F2C_ReqOpcodeQ502H,
   input  logic [31:0]           F2C_ReqAddressQ502H,
   input  logic [31:0]           F2C_ReqDataQ502H,
   output logic                  F2C_ReqStall,
   output logic [NUM_MEM-1:0]    MemReqValidQ503H,
   output logic                  MemReqWrEnQ503H,
   output logic [31:0]           MemReqAddressQ503H,
   output logic [31:0]           MemReqDataQ503H,
   input  logic [NUM_MEM*32-1:0] MemRspDataQ503H_LAT,
   output logic                  F2C_RspValidQ500H,
   output t_opcode               F2C_RspOpcodeQ500H,
   output logic [31:0]           F2C_RspAddressQ500H,
   output logic [31:0]           F2C_RspDataQ500H,
   input  logic                  F2C_RspReady,
   output logic [7:0]            ErrCnt,
   output logic [7:0]            DropCnt
);
   localparam int AW = $clog2(RSP_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(RSP_FIFO_DEPTH);
   localparam logic [2:0]    C_NMEM  = 3'(NUM_MEM);

   logic            r_q3_vld;
   t_opcode         r_q3_op;
   logic [31:0]     r_q3_addr, r_q3_data;
   logic [CW-1:0]   r_rsv;
   logic [7:0]      r_err, r_drop;

   logic [MEM_RD_LAT-1:0] r_vld_pipe;
   logic [1:0]      r_reg_pipe  [MEM_RD_LAT];
   logic            r_bad_pipe  [MEM_RD_LAT];
   logic [31:0]     r_addr_pipe [MEM_RD_LAT];

   logic [31:0]     r_fa [RSP_FIFO_DEPTH];
   logic [31:0]     r_fd [RSP_FIFO_DEPTH];
   logic [AW-1:0]   r_wp, r_rp;
   logic [CW-1:0]   r_fcnt;

   logic            r_o_vld;
   t_opcode         r_o_op;
   logic [31:0]     r_o_addr, r_o_data;

   logic            w_acc, w_acc_rd, w_bad, w_q3_rd;
   logic [1:0]      w_region;
   logic [31:0]     w_mem_rd [4];
   logic            w_push, w_pop, w_load, w_fempty, w_f_wr, w_f_rd;
   logic [31:0]     w_push_addr, w_push_data;

   assign F2C_ReqStall = (r_rsv >= C_DEPTH);
   assign w_acc        = F2C_ReqValidQ502H && !F2C_ReqStall;
   assign w_acc_rd     = w_acc && (F2C_ReqOpcodeQ502H == RD);

   assign w_region = r_q3_addr[REGION_LSB+1:REGION_LSB];
   assign w_bad    = ({1'b0, w_region} >= C_NMEM);
   assign w_q3_rd  = r_q3_vld && (r_q3_op == RD);

   always_comb begin
      MemReqValidQ503H = '0;
      for (int m = 0; m < NUM_MEM; m++)
         MemReqValidQ503H[m] = r_q3_vld && !w_bad && (w_region == 2'(m));
   end
   assign MemReqWrEnQ503H    = r_q3_vld && !w_bad && (r_q3_op == WR);
   assign MemReqAddressQ503H = r_q3_addr;
   assign MemReqDataQ503H    = r_q3_data;

   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         r_q3_vld  <= 1'b0;
         r_q3_op   <= NOP;
         r_q3_addr <= '0;
         r_q3_data <= '0;
      end else begin
         r_q3_vld <= w_acc;
         if (w_acc) begin
            r_q3_op   <= F2C_ReqOpcodeQ502H;
            r_q3_addr <= F2C_ReqAddressQ502H;
            r_q3_data <= F2C_ReqDataQ502H;
         end
      end
   end

   // Unpopulated region slots read as zero; only reachable through the bad path anyway.
   for (genvar g = 0; g < 4; g++) begin : g_rd
      if (g < NUM_MEM) begin : g_pop
         assign w_mem_rd[g] = MemRspDataQ503H_LAT[g*32 +: 32];
      end else begin : g_nopop
         assign w_mem_rd[g] = '0;
      end
   end

   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         r_vld_pipe <= '0;
         for (int i = 0; i < MEM_RD_LAT; i++) begin
            r_reg_pipe[i]  <= '0;
            r_bad_pipe[i]  <= 1'b0;
            r_addr_pipe[i] <= '0;
         end
      end else begin
         r_vld_pipe[0]  <= w_q3_rd;
         r_reg_pipe[0]  <= w_region;
         r_bad_pipe[0]  <= w_bad;
         r_addr_pipe[0] <= r_q3_addr;
         for (int i = 1; i < MEM_RD_LAT; i++) begin
            r_vld_pipe[i]  <= r_vld_pipe[i-1];
            r_reg_pipe[i]  <= r_reg_pipe[i-1];
            r_bad_pipe[i]  <= r_bad_pipe[i-1];
            r_addr_pipe[i] <= r_addr_pipe[i-1];
         end
      end
   end

   assign w_push      = r_vld_pipe[MEM_RD_LAT-1];
   assign w_push_addr = r_addr_pipe[MEM_RD_LAT-1];
   assign w_push_data = r_bad_pipe[MEM_RD_LAT-1] ? 32'hDEAD_BEEF
                                                 : w_mem_rd[r_reg_pipe[MEM_RD_LAT-1]];

   // Output register refills whenever it is empty or being popped; an empty FIFO is bypassed.
   assign w_pop    = r_o_vld && F2C_RspReady;
   assign w_load   = !r_o_vld || F2C_RspReady;
   assign w_fempty = (r_fcnt == '0);
   assign w_f_rd   = w_load && !w_fempty;
   assign w_f_wr   = w_push && !(w_load && w_fempty);

   always_ff @(posedge QClk) begin
      if (w_f_wr) begin
         r_fa[r_wp] <= w_push_addr;
         r_fd[r_wp] <= w_push_data;
      end
   end

   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_fcnt   <= '0;
         r_o_vld  <= 1'b0;
         r_o_op   <= NOP;
         r_o_addr <= '0;
         r_o_data <= '0;
      end else begin
         if (w_f_wr) r_wp <= r_wp + 1'b1;
         if (w_f_rd) r_rp <= r_rp + 1'b1;
         case ({w_f_wr, w_f_rd})
            2'b10:   r_fcnt <= r_fcnt + 1'b1;
            2'b01:   r_fcnt <= r_fcnt - 1'b1;
            default: r_fcnt <= r_fcnt;
         endcase
         if (w_load) begin
            if (!w_fempty) begin
               r_o_vld  <= 1'b1;
               r_o_op   <= RD_RSP;
               r_o_addr <= r_fa[r_rp];
               r_o_data <= r_fd[r_rp];
            end else if (w_push) begin
               r_o_vld  <= 1'b1;
               r_o_op   <= RD_RSP;
               r_o_addr <= w_push_addr;
               r_o_data <= w_push_data;
            end else begin
               r_o_vld  <= 1'b0;
               r_o_op   <= NOP;
            end
         end
      end
   end

   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         r_rsv  <= '0;
         r_err  <= '0;
         r_drop <= '0;
      end else begin
         case ({w_acc_rd, w_pop})
            2'b10:   r_rsv <= r_rsv + 1'b1;
            2'b01:   r_rsv <= r_rsv - 1'b1;
            default: r_rsv <= r_rsv;
         endcase
         if (r_q3_vld && w_bad && r_err != 8'hFF) r_err <= r_err + 8'd1;
         if (F2C_ReqValidQ502H && F2C_ReqStall && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
   end

   assign F2C_RspValidQ500H   = r_o_vld;
   assign F2C_RspOpcodeQ500H  = r_o_op;
   assign F2C_RspAddressQ500H = r_o_addr;
   assign F2C_RspDataQ500H    = r_o_data;
   assign ErrCnt              = r_err;
   assign DropCnt             = r_drop;

endmodule
